// File: rtl/l2_icache_resp.sv
// -----------------------------------------------------------------------------
// l2_icache_resp
//
// L2 responder for instruction-cache fill requests. A READ request is latched
// in IDLE. The two-way L2 tag/data arrays are read with a registered read, so
// the lookup is evaluated one cycle later. A hit returns the way's block
// straight to the icache. A miss picks a victim way, fetches the block from
// memory, then writes it into the victim way and forwards it to the icache in
// the same cycle. Every transaction ends with a one-cycle `complete` pulse.
// No victim writeback is done, because instruction lines are never dirty.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   irq, l2_addr,       icache request; irq held until complete;
//   l2_cache_rw         only READ (0) is serviced
//   l2_busy             responder is inside a transaction
//   l2_rdy              1-cycle pulse: L2 hit data on data_wd_l2
//   mem_wr_ic_en        1-cycle pulse: memory fill data on data_wd_l2
//   data_wd_l2          block to the icache; 0 when neither pulse is active
//   complete            1-cycle end-of-transaction pulse
//   l2_index            array index: live l2_addr in IDLE, latched otherwise
//   l2_tag{0,1}_rd      way tags {valid, tag[18:0]}, registered read
//   l2_data{0,1}_rd     way data, registered read
//   l2_lru              0 = replace way 0, 1 = replace way 1
//   l2_block{0,1}_we    way tag+data write enables (never both)
//   l2_tag_wd           {1'b1, latched addr[27:9]}
//   l2_data_wd          equals mem_rd
//   lru_we, lru_wd      LRU update; new value points at the way not used
//   mem_req, mem_addr   memory block read request, held until mem_rdy
//   mem_rdy, mem_rd     memory data valid / data
// -----------------------------------------------------------------------------
module l2_icache_resp (
  input  logic         clk,
  input  logic         rst,
  input  logic         irq,
  input  logic [27:0]  l2_addr,
  input  logic         l2_cache_rw,
  output logic         l2_busy,
  output logic         l2_rdy,
  output logic         mem_wr_ic_en,
  output logic [127:0] data_wd_l2,
  output logic         complete,
  output logic [8:0]   l2_index,
  input  logic [19:0]  l2_tag0_rd,
  input  logic [19:0]  l2_tag1_rd,
  input  logic [127:0] l2_data0_rd,
  input  logic [127:0] l2_data1_rd,
  input  logic         l2_lru,
  output logic         l2_block0_we,
  output logic         l2_block1_we,
  output logic [19:0]  l2_tag_wd,
  output logic [127:0] l2_data_wd,
  output logic         lru_we,
  output logic         lru_wd,
  output logic         mem_req,
  output logic [27:0]  mem_addr,
  input  logic         mem_rdy,
  input  logic [127:0] mem_rd
);

  localparam logic READ = 1'b0;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOOKUP   = 2'd1;
  localparam logic [1:0] WAIT_MEM = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [27:0] addr_q;
  logic        victim_q;

  logic accept;
  logic hit0;
  logic hit1;
  logic lookup_hit;
  logic lookup_miss;
  logic hit_way;
  logic victim_nxt;
  logic fill;

  assign accept = (state == IDLE) && irq && (l2_cache_rw == READ);

  assign hit0 = l2_tag0_rd[19] && (l2_tag0_rd[18:0] == addr_q[27:9]);
  assign hit1 = l2_tag1_rd[19] && (l2_tag1_rd[18:0] == addr_q[27:9]);

  assign lookup_hit  = (state == LOOKUP) && (hit0 || hit1);
  assign lookup_miss = (state == LOOKUP) && !(hit0 || hit1);
  // Way 0 wins when both ways match.
  assign hit_way     = !hit0;

  // Fill an invalid way first, so LRU only decides when both ways hold lines.
  assign victim_nxt = !l2_tag0_rd[19] ? 1'b0 :
                      !l2_tag1_rd[19] ? 1'b1 : l2_lru;

  assign fill = (state == WAIT_MEM) && mem_rdy;

  // NOTE: next-state logic is combinational. Assigning the default first
  // means every path writes state_nxt, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = LOOKUP;
      LOOKUP:   state_nxt = lookup_hit ? DONE : WAIT_MEM;
      WAIT_MEM: if (mem_rdy) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All of them then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      victim_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)      addr_q   <= l2_addr;
      if (lookup_miss) victim_q <= victim_nxt;
    end
  end

  assign l2_busy  = (state != IDLE);
  // In IDLE the live address drives the array, so the registered tag/data
  // read is ready for the LOOKUP cycle that follows.
  assign l2_index = (state == IDLE) ? l2_addr[8:0] : addr_q[8:0];

  assign l2_rdy       = lookup_hit;
  assign mem_wr_ic_en = fill;
  assign complete     = (state == DONE);

  assign data_wd_l2 = lookup_hit ? (hit_way ? l2_data1_rd : l2_data0_rd) :
                      fill       ? mem_rd : '0;

  assign l2_block0_we = fill && !victim_q;
  assign l2_block1_we = fill &&  victim_q;
  assign l2_tag_wd    = {1'b1, addr_q[27:9]};
  assign l2_data_wd   = mem_rd;

  assign lru_we = lookup_hit || fill;
  assign lru_wd = lookup_hit ? !hit_way : !victim_q;

  assign mem_req  = (state == WAIT_MEM);
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_l2_icache_resp.sv
// -----------------------------------------------------------------------------
// tb_l2_icache_resp
//
// Bench for l2_icache_resp. It contains a two-way L2 array model with
// registered reads and a transaction-level reference. At acceptance, the
// reference resolves hit, hit way or victim from the array contents. It then
// predicts which cycle carries the data, the writes and the complete pulse.
// Directed transactions also pin literal latencies and values.
// -----------------------------------------------------------------------------
module tb_l2_icache_resp;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic         irq;
  logic [27:0]  l2_addr;
  logic         l2_cache_rw;
  logic         l2_busy, l2_rdy, mem_wr_ic_en, complete;
  logic [127:0] data_wd_l2;
  logic [8:0]   l2_index;
  logic [19:0]  l2_tag0_rd, l2_tag1_rd;
  logic [127:0] l2_data0_rd, l2_data1_rd;
  logic         l2_lru;
  logic         l2_block0_we, l2_block1_we;
  logic [19:0]  l2_tag_wd;
  logic [127:0] l2_data_wd;
  logic         lru_we, lru_wd, mem_req;
  logic [27:0]  mem_addr;
  logic         mem_rdy;
  logic [127:0] mem_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_icache_resp dut (
    .clk(clk), .rst(rst), .irq(irq), .l2_addr(l2_addr), .l2_cache_rw(l2_cache_rw),
    .l2_busy(l2_busy), .l2_rdy(l2_rdy), .mem_wr_ic_en(mem_wr_ic_en),
    .data_wd_l2(data_wd_l2), .complete(complete), .l2_index(l2_index),
    .l2_tag0_rd(l2_tag0_rd), .l2_tag1_rd(l2_tag1_rd),
    .l2_data0_rd(l2_data0_rd), .l2_data1_rd(l2_data1_rd), .l2_lru(l2_lru),
    .l2_block0_we(l2_block0_we), .l2_block1_we(l2_block1_we),
    .l2_tag_wd(l2_tag_wd), .l2_data_wd(l2_data_wd),
    .lru_we(lru_we), .lru_wd(lru_wd), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdy(mem_rdy), .mem_rd(mem_rd)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- L2 array model (registered read) ----------------
  logic [19:0]  tag0_a [512];
  logic [19:0]  tag1_a [512];
  logic [127:0] data0_a[512];
  logic [127:0] data1_a[512];
  logic         lru_a  [512];

  always @(posedge clk) begin
    l2_tag0_rd  <= tag0_a[l2_index];
    l2_tag1_rd  <= tag1_a[l2_index];
    l2_data0_rd <= data0_a[l2_index];
    l2_data1_rd <= data1_a[l2_index];
    l2_lru      <= lru_a[l2_index];
    if (l2_block0_we) begin tag0_a[l2_index] <= l2_tag_wd; data0_a[l2_index] <= l2_data_wd; end
    if (l2_block1_we) begin tag1_a[l2_index] <= l2_tag_wd; data1_a[l2_index] <= l2_data_wd; end
    if (lru_we) lru_a[l2_index] <= lru_wd;
  end

  // ---------------- transaction-level reference + compare ----------------
  logic         m_busy = 1'b0;
  logic         m_lookup, m_done, m_hit, m_way;
  logic [27:0]  m_addr;
  logic [127:0] m_hdata;

  initial begin : compare
    logic e_busy, e_rdy, e_fill, e_cmp, e_we0, e_we1, e_lwe, e_lwd, e_req;
    logic [127:0] e_data;
    logic [8:0] e_idx, ix;
    logic h0, h1;
    forever begin
      @(negedge clk);
      #3;
      e_busy = 0; e_rdy = 0; e_fill = 0; e_cmp = 0; e_we0 = 0; e_we1 = 0;
      e_lwe = 0; e_lwd = 0; e_req = 0; e_data = '0; e_idx = l2_addr[8:0];
      if (!rst && m_busy) begin
        e_busy = 1;
        e_idx  = m_addr[8:0];
        if (m_done) e_cmp = 1;
        else if (m_lookup) begin
          if (m_hit) begin e_rdy = 1; e_data = m_hdata; e_lwe = 1; e_lwd = !m_way; end
        end else begin
          e_req = 1;
          if (mem_rdy) begin
            e_fill = 1; e_data = mem_rd; e_we0 = !m_way; e_we1 = m_way;
            e_lwe = 1; e_lwd = !m_way;
          end
        end
      end
      check("busy", l2_busy, e_busy);
      check("l2_rdy", l2_rdy, e_rdy);
      check("mem_wr_ic_en", mem_wr_ic_en, e_fill);
      check("complete", complete, e_cmp);
      check("data_wd_l2", data_wd_l2, e_data);
      check("block0_we", l2_block0_we, e_we0);
      check("block1_we", l2_block1_we, e_we1);
      check("lru_we", lru_we, e_lwe);
      check("mem_req", mem_req, e_req);
      check("l2_index", l2_index, e_idx);
      check("l2_data_wd", l2_data_wd, mem_rd);
      if (e_lwe) check("lru_wd", lru_wd, e_lwd);
      if (e_req) check("mem_addr", mem_addr, m_addr);
      if (e_we0 || e_we1) check("l2_tag_wd", l2_tag_wd, {1'b1, m_addr[27:9]});
      // Advance the reference across the coming rising edge.
      if (rst) m_busy = 0;
      else if (!m_busy) begin
        if (irq && l2_cache_rw == READ) begin
          m_busy = 1; m_lookup = 1; m_done = 0; m_addr = l2_addr;
          ix = l2_addr[8:0];
          h0 = tag0_a[ix][19] && tag0_a[ix][18:0] == l2_addr[27:9];
          h1 = tag1_a[ix][19] && tag1_a[ix][18:0] == l2_addr[27:9];
          m_hit   = h0 || h1;
          m_hdata = h0 ? data0_a[ix] : data1_a[ix];
          if (m_hit) m_way = !h0;
          else       m_way = !tag0_a[ix][19] ? 1'b0 : !tag1_a[ix][19] ? 1'b1 : lru_a[ix];
        end
      end
      else if (m_done) m_busy = 0;
      else if (m_lookup) begin m_done = m_hit; m_lookup = 0; end
      else if (mem_rdy) m_done = 1;
    end
  end

  // ---------------- directed stimulus ----------------
  int           r_rdy_c, r_fill_c, r_cmp_c, r_ncmp, r_nreq, r_we0, r_we1;
  logic [127:0] r_data;
  logic         r_lwd;
  logic [19:0]  r_tagwd;

  task automatic run_txn(input logic [27:0] addr, input int mem_delay, input logic [127:0] fill);
    r_rdy_c = -1; r_fill_c = -1; r_cmp_c = -1; r_ncmp = 0; r_nreq = 0; r_we0 = 0; r_we1 = 0;
    r_data = '0; r_lwd = 0; r_tagwd = '0;
    @(negedge clk);
    irq = 1; l2_addr = addr; l2_cache_rw = READ;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (mem_req) begin
        r_nreq++;
        if (r_nreq == mem_delay) begin mem_rdy = 1; mem_rd = fill; end
      end
      #1;
      if (l2_rdy) begin r_rdy_c = c; r_data = data_wd_l2; r_lwd = lru_wd; end
      if (mem_wr_ic_en) begin r_fill_c = c; r_data = data_wd_l2; r_lwd = lru_wd; r_tagwd = l2_tag_wd; end
      if (l2_block0_we) r_we0++;
      if (l2_block1_we) r_we1++;
      if (complete) begin r_cmp_c = c; r_ncmp++; end
      @(negedge clk);
      mem_rdy = 0;
      if (r_cmp_c >= 0) break;
    end
    if (r_cmp_c < 0) check("txn_timeout", 1'b1, 1'b0);
    irq = 0;
    // Two idle cycles: a duplicate transaction would show up here.
    for (int c = 0; c < 2; c++) begin
      #2;
      if (complete) r_ncmp++;
      if (l2_busy) check("idle_after_txn_busy", l2_busy, 1'b0);
      @(negedge clk);
    end
  endtask

  localparam logic [127:0] D0   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DA5  = {16{8'hA5}};
  localparam logic [127:0] DWA  = 128'h0A0A_0A0A_0A0A_0A0A_0A0A_0A0A_0A0A_0A0A;
  localparam logic [127:0] DWB  = 128'h0B0B_0B0B_0B0B_0B0B_0B0B_0B0B_0B0B_0B0B;
  localparam logic [127:0] DF   = 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF;
  localparam logic [127:0] DX   = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;

  initial begin
    for (int i = 0; i < 512; i++) begin
      tag0_a[i] = '0; tag1_a[i] = '0; data0_a[i] = '0; data1_a[i] = '0; lru_a[i] = 0;
    end
    tag0_a[9'h123] = 20'h80000;  data0_a[9'h123] = D0;              // hit on way 0
    tag0_a[9'h000] = 20'h80005;  tag1_a[9'h000] = 20'h80006; lru_a[9'h000] = 1;  // both valid, lru=1
    tag0_a[9'h001] = 20'h80005;  tag1_a[9'h001] = 20'h80005;
    data0_a[9'h001] = DWA;       data1_a[9'h001] = DWB;             // both ways match

    rst = 1; irq = 0; l2_addr = '0; l2_cache_rw = READ; mem_rdy = 0; mem_rd = '0;
    #2;
    check("reset_busy", l2_busy, 1'b0);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_mem_addr", mem_addr, 28'h0);
    check("reset_tag_wd", l2_tag_wd, 20'h80000);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Hit on way 0.
    run_txn(28'h0000123, 1, '0);
    check("hit_rdy_cycle", r_rdy_c, 1);
    check("hit_data", r_data, D0);
    check("hit_lru_wd", r_lwd, 1'b1);
    check("hit_complete_cycle", r_cmp_c, 2);
    check("hit_no_write", r_we0 + r_we1, 0);
    check("hit_one_complete", r_ncmp, 1);

    // Miss, way 0 invalid: tag = 0xABCD456 >> 9 = 0x55E6A.
    run_txn(28'hABCD456, 5, DA5);
    check("miss_req_cycles", r_nreq, 5);
    check("miss_fill_cycle", r_fill_c, 6);
    check("miss_complete_cycle", r_cmp_c, 7);
    check("miss_we0", r_we0, 1);
    check("miss_we1", r_we1, 0);
    check("miss_tag_wd", r_tagwd, 20'hD5E6A);
    check("miss_data", r_data, DA5);
    check("miss_lru_wd", r_lwd, 1'b1);

    // The same address now hits the block that was just filled.
    run_txn(28'hABCD456, 1, '0);
    check("refill_hit_cycle", r_rdy_c, 1);
    check("refill_hit_data", r_data, DA5);

    // Miss with both ways valid and lru=1: way 1 replaced.
    run_txn(28'h0000200, 2, DF);
    check("lru_miss_we1", r_we1, 1);
    check("lru_miss_we0", r_we0, 0);
    check("lru_miss_lru_wd", r_lwd, 1'b0);
    check("lru_miss_tag_wd", r_tagwd, 20'h80001);

    // Both ways match: way 0 wins, nothing written.
    run_txn(28'h0000A01, 1, '0);
    check("dual_hit_data", r_data, DWA);
    check("dual_hit_no_write", r_we0 + r_we1, 0);
    check("dual_hit_lru_wd", r_lwd, 1'b1);
    check("dual_hit_one_complete", r_ncmp, 1);

    // WRITE request ignored.
    @(negedge clk);
    irq = 1; l2_cache_rw = WRITE; l2_addr = 28'h0000123;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("write_ignored_busy", l2_busy, 1'b0);
      @(negedge clk);
    end
    irq = 0; l2_cache_rw = READ;

    // Reset during WAIT_MEM aborts; a late mem_rdy must not write.
    @(negedge clk);
    irq = 1; l2_addr = 28'h1234567;
    begin : wait_req
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (mem_req) disable wait_req;
      end
      check("abort_wait_req_timeout", 1'b1, 1'b0);
    end
    rst = 1; irq = 0;
    #1;
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_busy", l2_busy, 1'b0);
    check("abort_mem_addr", mem_addr, 28'h0);
    @(negedge clk);
    rst = 0; mem_rdy = 1; mem_rd = DX;
    #1;
    check("abort_late_we", {l2_block0_we, l2_block1_we, mem_wr_ic_en}, 3'b000);
    @(negedge clk);
    mem_rdy = 0;
    #1;
    check("abort_no_complete", complete, 1'b0);
    @(negedge clk); @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_icache_resp.md
L2_ICACHE_RESP -- requirements
Module: l2_icache_resp

Interface
REQ-001 The block SHALL use one clock and an asynchronously asserted, active-high reset.
REQ-002 Port `clk`, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 Port `rst`, input, 1 bit: asynchronous active-high reset.
REQ-004 Port `irq`, input, 1 bit: icache fill request, held by the requester until `complete`.
REQ-005 Port `l2_addr`, input, 28 bits: requested block address; index = [8:0], tag = [27:9].
REQ-006 Port `l2_cache_rw`, input, 1 bit: request direction; only `READ` is serviced.
REQ-007 Port `l2_busy`, output, 1 bit: responder cannot accept a new request.
REQ-008 Port `l2_rdy`, output, 1 bit: one-cycle pulse; L2 hit data is valid on `data_wd_l2`.
REQ-009 Port `mem_wr_ic_en`, output, 1 bit: one-cycle pulse; memory fill data is valid on `data_wd_l2`.
REQ-010 Port `data_wd_l2`, output, 128 bits: block returned to the icache.
REQ-011 Port `complete`, output, 1 bit: one-cycle pulse ending the transaction.
REQ-012 Port `l2_index`, output, 9 bits: L2 array index.
REQ-013 Port `l2_tag0_rd`, input, 20 bits: L2 way-0 tag, registered read; bit 19 = valid, [18:0] = tag.
REQ-014 Port `l2_tag1_rd`, input, 20 bits: L2 way-1 tag, same format as way 0.
REQ-015 Port `l2_data0_rd`, input, 128 bits: L2 way-0 data, registered read.
REQ-016 Port `l2_data1_rd`, input, 128 bits: L2 way-1 data, registered read.
REQ-017 Port `l2_lru`, input, 1 bit: LRU bit; 0 = replace way 0, 1 = replace way 1.
REQ-018 Port `l2_block0_we`, output, 1 bit: way-0 tag and data write enable.
REQ-019 Port `l2_block1_we`, output, 1 bit: way-1 tag and data write enable.
REQ-020 Port `l2_tag_wd`, output, 20 bits: tag write data, always {1'b1, latched addr[27:9]}.
REQ-021 Port `l2_data_wd`, output, 128 bits: data write data, always equal to `mem_rd`.
REQ-022 Port `lru_we`, output, 1 bit: LRU bit write enable.
REQ-023 Port `lru_wd`, output, 1 bit: new LRU value.
REQ-024 Port `mem_req`, output, 1 bit: memory block read request.
REQ-025 Port `mem_addr`, output, 28 bits: block address sent to memory.
REQ-026 Port `mem_rdy`, input, 1 bit: memory data valid.
REQ-027 Port `mem_rd`, input, 128 bits: memory block data.

Function
REQ-028 The state machine SHALL have four states: IDLE, LOOKUP, WAIT_MEM and DONE.
REQ-029 In IDLE, `l2_busy` SHALL be 0 and `l2_index` SHALL equal `l2_addr[8:0]` combinationally; in every other state `l2_index` SHALL equal the latched address bits [8:0].
REQ-030 In IDLE, when `irq` = 1 and `l2_cache_rw` = `READ`, the block SHALL latch `l2_addr` and move to LOOKUP; otherwise it SHALL stay in IDLE.
REQ-031 An `irq` with `l2_cache_rw` = `WRITE` SHALL be ignored.
REQ-032 `l2_busy` SHALL be 1 in LOOKUP, WAIT_MEM and DONE.
REQ-033 In LOOKUP, hit on way n SHALL mean valid bit = 1 and tag[18:0] == latched addr[27:9]; if both ways match, way 0 SHALL win.
REQ-034 On a LOOKUP hit, in that same cycle the block SHALL assert `l2_rdy`, drive `data_wd_l2` with the hit way's data, pulse `lru_we` with `lru_wd` = the way not hit, and move to DONE.
REQ-035 On a LOOKUP miss, the block SHALL choose a victim: way 0 if way 0 is invalid; else way 1 if way 1 is invalid; else the way given by `l2_lru`.
REQ-036 On a LOOKUP miss, the block SHALL register the victim and move to WAIT_MEM.
REQ-037 In WAIT_MEM, `mem_req` SHALL be 1 and `mem_addr` SHALL equal the latched address, held until `mem_rdy` = 1.
REQ-038 On `mem_rdy` in WAIT_MEM, in the same cycle the block SHALL pulse the victim's `l2_blockN_we`, drive `data_wd_l2` = `mem_rd`, pulse `mem_wr_ic_en`, and pulse `lru_we` with `lru_wd` = the way not written.
REQ-039 After `mem_rdy` in WAIT_MEM, the next state SHALL be DONE, and `mem_req` SHALL deassert in the following cycle.
REQ-040 In DONE, `complete` SHALL be 1 for exactly one cycle, `irq` SHALL be ignored, and the next state SHALL be IDLE.
REQ-041 Victim writeback SHALL NOT be performed.
REQ-042 At most one of `l2_block0_we` and `l2_block1_we` SHALL be asserted in any cycle.
REQ-043 `l2_rdy` and `mem_wr_ic_en` SHALL never be asserted together.
REQ-044 Hit latency SHALL be: `irq` accepted in cycle 0, `l2_rdy` in cycle 1, `complete` in cycle 2.
REQ-045 Miss latency SHALL be: `mem_rdy` in cycle k, `complete` in cycle k+1.
REQ-046 `data_wd_l2` SHALL be 0 whenever neither `l2_rdy` nor `mem_wr_ic_en` is asserted.

Reset
REQ-047 While `rst` = 1, the state SHALL be IDLE and every output pulse/enable (`l2_busy`, `l2_rdy`, `mem_wr_ic_en`, `complete`, `l2_block0_we`, `l2_block1_we`, `lru_we`, `mem_req`) SHALL be 0.
REQ-048 While `rst` = 1, the latched address and latched victim SHALL be 0, so `mem_addr` = 0 and `l2_tag_wd` = {1'b1, 19'h0}.
REQ-049 Reset asserted in any state SHALL abort the transaction immediately (asynchronously); no array write or `complete` SHALL follow.

Verification
REQ-050 Hit: way0 tag = {1, addr[27:9]}, `irq` with `l2_addr` = 28'h0000123 -> `l2_rdy` next cycle, `data_wd_l2` = way-0 data, `lru_wd` = 1, `complete` one cycle later.
REQ-051 Miss with way 0 invalid: `mem_req` held 5 cycles until `mem_rdy`, `mem_rd` = 128'hA5... -> `l2_block0_we` = 1, `l2_tag_wd` = {1, tag}, `mem_wr_ic_en` = 1, `data_wd_l2` = 128'hA5...
REQ-052 Miss with both ways valid and `l2_lru` = 1 -> `l2_block1_we` pulsed and `lru_wd` = 0.
REQ-053 Both ways match -> way-0 data returned and no write enable asserted.
REQ-054 `irq` held high through DONE -> exactly one transaction and one `complete` pulse; a `WRITE` request is ignored with `l2_busy` = 0.
REQ-055 `rst` asserted during WAIT_MEM -> `mem_req` and `l2_busy` go 0 immediately; `mem_rdy` arriving afterwards causes no write.
